// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard detector and stall sequencer for the RV32I 5-stage pipeline.
// Combinational outputs from registered state; single-cycle stalls stay in RUN, longer ones count down in STALL.
module hazard_stall_ctrl #(
  parameter int INSTR_W   = 32,
  parameter int REG_AW    = 5,
  parameter int MEM_DELAY = 4,
  parameter int BR_STALL  = 1,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               flush,
  input  logic               ext_stall,
  output logic               pc_en,
  output logic               fd_en,
  output logic               de_en,
  output logic               de_bubble,
  output logic [1:0]         hazard_type,
  output logic               busy
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] HZ_NONE     = 2'b00;
  localparam logic [1:0] HZ_LOAD_USE = 2'b01;
  localparam logic [1:0] HZ_ALU_BR   = 2'b10;
  localparam logic [1:0] HZ_LOAD_BR  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MEM_N = CNT_W'(MEM_DELAY);
  localparam logic [CNT_W-1:0] CNT_BR_N  = CNT_W'(BR_STALL);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_STALL
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        type_q, type_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [6:0]        ex_op_q, ex_op_d;

  logic [6:0]        dec_op;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;

  logic              haz_match;
  logic              haz_vld;
  logic [1:0]        haz_type;
  logic [CNT_W-1:0]  haz_n;

  // Funct fields do not affect operand usage.
  logic unused_bits;
  assign unused_bits = ^{instr_in[INSTR_W-1:25], instr_in[14:12]};

  always_comb begin
    dec_op  = 7'd0;
    dec_rs1 = '0;
    dec_rs2 = '0;
    dec_rd  = '0;
    if (instr_valid) begin
      dec_op  = instr_in[6:0];
      dec_rs1 = instr_in[15 +: REG_AW];
      dec_rd  = instr_in[7 +: REG_AW];
      if (dec_op == OP_JAL || dec_op == OP_LUI || dec_op == OP_AUIPC)
        dec_rs1 = '0;
      if (dec_op == OP_BRANCH || dec_op == OP_STORE || dec_op == OP_OP)
        dec_rs2 = instr_in[20 +: REG_AW];
      if (dec_op == OP_BRANCH || dec_op == OP_STORE)
        dec_rd = '0;
    end
  end

  // A zero ex_rd never matches, so x0 and bubbles are hazard-free.
  always_comb begin
    haz_match = (ex_rd_q != '0) && ((dec_rs1 == ex_rd_q) || (dec_rs2 == ex_rd_q));
    haz_vld   = 1'b0;
    haz_type  = HZ_NONE;
    haz_n     = CNT_ONE;
    if (haz_match && ex_op_q == OP_LOAD) begin
      haz_vld = 1'b1;
      if (dec_op == OP_BRANCH) begin
        haz_type = HZ_LOAD_BR;
        haz_n    = CNT_MEM_N;
      end else begin
        haz_type = HZ_LOAD_USE;
      end
    end else if (haz_match && dec_op == OP_BRANCH) begin
      haz_vld  = 1'b1;
      haz_type = HZ_ALU_BR;
      haz_n    = CNT_BR_N;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    de_en       = 1'b1;
    de_bubble   = 1'b0;
    hazard_type = HZ_NONE;
    busy        = (state_q == ST_STALL);

    if (flush) begin
      de_bubble = 1'b1;
      state_d   = ST_RUN;
      cnt_d     = '0;
    end else if (state_q == ST_RESET) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
      state_d   = ST_RUN;
    end else if (ext_stall) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      if (state_q == ST_STALL)
        hazard_type = type_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (haz_vld) begin
            pc_en       = 1'b0;
            fd_en       = 1'b0;
            de_bubble   = 1'b1;
            hazard_type = haz_type;
            // Single-cycle stalls resolve themselves once the bubble clears ex_rd.
            if (haz_n > CNT_ONE) begin
              state_d = ST_STALL;
              cnt_d   = haz_n - CNT_ONE;
              type_d  = haz_type;
            end
          end
        end
        ST_STALL: begin
          pc_en       = 1'b0;
          fd_en       = 1'b0;
          de_bubble   = 1'b1;
          hazard_type = type_q;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ex_rd_d = ex_rd_q;
    ex_op_d = ex_op_q;
    if (de_en) begin
      if (de_bubble) begin
        ex_rd_d = '0;
        ex_op_d = 7'd0;
      end else begin
        ex_rd_d = dec_rd;
        ex_op_d = dec_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      type_q  <= HZ_NONE;
      ex_rd_q <= '0;
      ex_op_q <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      ex_rd_q <= ex_rd_d;
      ex_op_q <= ex_op_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed pipeline sequences then random traffic,
// expected outputs come from a stall-countdown model of the pipeline rules.
module tb_hazard_stall_ctrl;

  localparam int MEM_DELAY = 4;
  localparam int BR_STALL  = 1;

  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        flush;
  logic        ext_stall;
  logic        pc_en, fd_en, de_en, de_bubble, busy;
  logic [1:0]  hazard_type;

  hazard_stall_ctrl #(
    .INSTR_W(32), .REG_AW(5), .MEM_DELAY(MEM_DELAY), .BR_STALL(BR_STALL), .CNT_W(4)
  ) dut (
    .clk(clk), .nrst(nrst), .instr_in(instr_in), .instr_valid(instr_valid),
    .flush(flush), .ext_stall(ext_stall), .pc_en(pc_en), .fd_en(fd_en),
    .de_en(de_en), .de_bubble(de_bubble), .hazard_type(hazard_type), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // {pc_en, fd_en, de_en, de_bubble, hazard_type[1:0], busy}
  logic [6:0] exp_q[$];

  // Model state: pending extra stall cycles, latched type, what sits in EX.
  bit          m_known = 0;
  bit          m_reset = 0;
  int          m_rem   = 0;
  logic [1:0]  m_lat   = 2'b00;
  int          m_ex_rd = 0;
  bit          m_ex_ld = 0;
  bit          last_fd = 1;
  logic [31:0] cur_instr = 32'h0000_0013;
  logic        cur_valid = 1'b1;

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    logic [4:0] a, b, c;
    a = 5'(rd); b = 5'(rs1); c = 5'(rs2);
    return {7'(($urandom() & 32'h7f)), c, b, 3'(($urandom() & 32'h7)), a, op};
  endfunction

  function automatic void decode(input logic [31:0] ins, input logic v,
                                 output int rs1, output int rs2, output int rd,
                                 output bit ld, output bit br);
    logic [6:0] op;
    op = ins[6:0];
    rs1 = 0; rs2 = 0; rd = 0; ld = 0; br = 0;
    if (v) begin
      rs1 = (op == JAL || op == LUI || op == AUIPC) ? 0 : int'(ins[19:15]);
      rs2 = (op == BR || op == ST || op == OPR) ? int'(ins[24:20]) : 0;
      rd  = (op == BR || op == ST) ? 0 : int'(ins[11:7]);
      ld  = (op == LD);
      br  = (op == BR);
    end
  endfunction

  // One clock of pipeline: IF/ID holds its instruction whenever fd_en was low.
  task automatic step(input bit r, input bit f, input bit e, input logic [31:0] ni, input logic nv);
    int rs1, rs2, rd, n;
    bit ld, br, haz, bz;
    logic [1:0] ht;
    logic [6:0] ex;
    bit n_known, n_reset, n_ex_ld;
    int n_rem, n_ex_rd;
    logic [1:0] n_lat;
    if (!(m_known && !last_fd)) begin
      cur_instr = ni;
      cur_valid = nv;
    end
    nrst = r; flush = f; ext_stall = e;
    instr_in = cur_instr; instr_valid = cur_valid;
    n_known = m_known; n_reset = m_reset; n_rem = m_rem; n_lat = m_lat;
    n_ex_rd = m_ex_rd; n_ex_ld = m_ex_ld;
    if (m_known) begin
      decode(cur_instr, cur_valid, rs1, rs2, rd, ld, br);
      haz = 0; ht = 2'b00; n = 0;
      if (m_ex_rd != 0 && (rs1 == m_ex_rd || rs2 == m_ex_rd)) begin
        if (m_ex_ld) begin
          haz = 1; ht = br ? 2'b11 : 2'b01; n = br ? MEM_DELAY : 1;
        end else if (br) begin
          haz = 1; ht = 2'b10; n = BR_STALL;
        end
      end
      bz = (m_rem > 0);
      if (f) begin
        ex = {4'b1111, 2'b00, bz};
        n_reset = 0; n_rem = 0; n_ex_rd = 0; n_ex_ld = 0;
      end else if (m_reset) begin
        ex = {4'b0011, 2'b00, 1'b0};
        n_reset = 0; n_ex_rd = 0; n_ex_ld = 0;
      end else if (e) begin
        ex = {4'b0000, bz ? m_lat : 2'b00, bz};
      end else if (bz) begin
        ex = {4'b0011, m_lat, 1'b1};
        n_rem = m_rem - 1; n_ex_rd = 0; n_ex_ld = 0;
      end else if (haz) begin
        ex = {4'b0011, ht, 1'b0};
        n_rem = n - 1; n_lat = ht; n_ex_rd = 0; n_ex_ld = 0;
      end else begin
        ex = {4'b1110, 2'b00, 1'b0};
        n_ex_rd = rd; n_ex_ld = ld;
      end
      exp_q.push_back(ex);
      last_fd = ex[5];
    end else begin
      last_fd = 1;
    end
    if (!r) begin
      n_known = 1; n_reset = 1; n_rem = 0; n_ex_rd = 0; n_ex_ld = 0;
    end
    @(posedge clk);
    #1;
    m_known = n_known; m_reset = n_reset; m_rem = n_rem; m_lat = n_lat;
    m_ex_rd = n_ex_rd; m_ex_ld = n_ex_ld;
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    logic [6:0] e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_en, fd_en, de_en, de_bubble, hazard_type, busy};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: {pc,fd,de,bub,type,busy} got %b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
                   cyc, a[6], a[5], a[4], a[3], a[2:1], a[0], e[6], e[5], e[4], e[3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] nop, lw5, add6, beq5, add7, beq7, lw0, add1;
    nop  = 32'h0000_0013;
    lw5  = enc(LD, 5, 1, 0);
    add6 = enc(OPR, 6, 5, 2);
    beq5 = enc(BR, 0, 5, 0);
    add7 = enc(OPR, 7, 1, 2);
    beq7 = enc(BR, 0, 7, 3);
    lw0  = enc(LD, 0, 1, 0);
    add1 = enc(OPR, 1, 0, 0);

    step(0, 0, 0, nop, 1);
    step(0, 0, 0, nop, 1);
    // load-use
    step(1, 0, 0, lw5, 1); step(1, 0, 0, add6, 1);
    repeat (3) step(1, 0, 0, nop, 1);
    // load-branch
    step(1, 0, 0, lw5, 1); step(1, 0, 0, beq5, 1);
    repeat (6) step(1, 0, 0, nop, 1);
    // alu-branch, then x0 destination
    step(1, 0, 0, add7, 1); step(1, 0, 0, beq7, 1);
    repeat (3) step(1, 0, 0, nop, 1);
    step(1, 0, 0, lw0, 1); step(1, 0, 0, add1, 1);
    repeat (2) step(1, 0, 0, nop, 1);
    // flush at stall cycle 2
    step(1, 0, 0, lw5, 1); step(1, 0, 0, beq5, 1); step(1, 1, 0, nop, 1);
    repeat (3) step(1, 0, 0, nop, 1);
    // freeze mid-stall with two stall cycles left
    step(1, 0, 0, lw5, 1); step(1, 0, 0, beq5, 1); step(1, 0, 0, nop, 1);
    repeat (3) step(1, 0, 1, nop, 1);
    repeat (5) step(1, 0, 0, nop, 1);
    // reset mid-stall, then a would-be consumer of x5
    step(1, 0, 0, lw5, 1); step(1, 0, 0, beq5, 1); step(1, 0, 0, nop, 1);
    step(0, 0, 0, add6, 1);
    repeat (3) step(1, 0, 0, add6, 1);
    repeat (2) step(1, 0, 0, nop, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [6:0] ops[8];
      logic [31:0] ni;
      ops = '{LD, ST, BR, OPR, OPI, JAL, LUI, AUIPC};
      ni = enc(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ni, ($urandom_range(0, 7) != 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
